buffer_req: RTL and testbench

- Request-side buffer of the RPC DRAM controller; the ingress counterpart of the response buffer.
- Accepts AXI AW, W and AR beats and converts AXI byte addresses to DRAM word addresses.
- Queues AW/AR commands and write-data words, then issues one transaction at a time to the controller FSM (`trx_*`/`cmd_*`), gated by the response buffer's `buf_resp_ready`.
- A write is eligible only when its full burst of data is already buffered.

---
 rtl/buffer_req_if.sv | 46 ++++
 rtl/buffer_req.sv | 192 +++++++++++++++++++
 tb/tb_buffer_req.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_req_if.sv
// Request-side bundle of the RPC DRAM buffer: AXI AW/W/AR ingress,
// the command path to the controller FSM, and the PHY write-data path.
interface buffer_req_if #(
  parameter int DramDataWidth  = 256,
  parameter int DramStrbWidth  = DramDataWidth / 8,
  parameter int DramLenWidth   = 6,
  parameter int DramAddrWidth  = 24,
  parameter int AXI_ADDR_WIDTH = 48
);
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [DramLenWidth-1:0]   aw_len;
  logic                      aw_valid;
  logic                      aw_ready;
  logic [DramDataWidth-1:0]  w_data;
  logic [DramStrbWidth-1:0]  w_strb;
  logic                      w_valid;
  logic                      w_ready;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [DramLenWidth-1:0]   ar_len;
  logic                      ar_valid;
  logic                      ar_ready;
  logic                      trx_is_write;
  logic [DramLenWidth-1:0]   trx_len;
  logic [DramAddrWidth-1:0]  trx_addr;
  logic                      buf_resp_ready;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [DramDataWidth-1:0]  w_phy_data;
  logic [DramStrbWidth-1:0]  w_phy_strb;
  logic                      w_phy_valid;
  logic                      w_phy_ready;

  modport master (
    output aw_addr, aw_len, aw_valid, w_data, w_strb, w_valid,
    output ar_addr, ar_len, ar_valid, buf_resp_ready, cmd_ready, w_phy_ready,
    input  aw_ready, w_ready, ar_ready, trx_is_write, trx_len, trx_addr,
    input  cmd_valid, w_phy_data, w_phy_strb, w_phy_valid
  );

  modport slave (
    input  aw_addr, aw_len, aw_valid, w_data, w_strb, w_valid,
    input  ar_addr, ar_len, ar_valid, buf_resp_ready, cmd_ready, w_phy_ready,
    output aw_ready, w_ready, ar_ready, trx_is_write, trx_len, trx_addr,
    output cmd_valid, w_phy_data, w_phy_strb, w_phy_valid
  );
endinterface

// File: rtl/buffer_req.sv
// Request buffer: queues AW/AR commands and W words, converts byte to word
// addresses, and issues one transaction at a time to the controller FSM.
module buffer_req_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr_reg;
  logic [PtrWidth-1:0] rd_ptr_reg;
  logic [PtrWidth:0]   count_reg;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PtrWidth + 1)'(Depth));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

module buffer_req #(
  parameter int BufferDepth    = 4,
  parameter int DramDataWidth  = 256,
  parameter int DramStrbWidth  = DramDataWidth / 8,
  parameter int DramLenWidth   = 6,
  parameter int DramAddrWidth  = 24,
  parameter int AXI_ADDR_WIDTH = 48,
  parameter int WBufDepth      = BufferDepth << DramLenWidth
) (
  input logic        clk_i,
  input logic        rst_i,
  buffer_req_if.slave bus
);
  localparam int S           = $clog2(DramStrbWidth);
  localparam int CmdWidth    = DramAddrWidth + DramLenWidth;
  localparam int WWidth      = DramDataWidth + DramStrbWidth;
  localparam int CreditWidth = $clog2(WBufDepth) + 1;
  localparam int RdIdx       = 0;
  localparam int WrIdx       = 1;

  typedef enum logic {SELECT, ISSUE} state_t;

  state_t state_reg, state_next;

  logic [1:0]          cmd_push, cmd_pop, cmd_empty, cmd_full;
  logic [CmdWidth-1:0] cmd_in   [2];
  logic [CmdWidth-1:0] cmd_head [2];

  logic              w_push, w_pop, w_empty, w_full;
  logic [WWidth-1:0] w_head;

  logic [CreditWidth-1:0] w_credit_reg, w_credit_next;
  logic [CreditWidth-1:0] aw_need, sel_need;
  logic                   last_was_write_reg;
  logic                   trx_is_write_reg;
  logic [DramLenWidth-1:0]  trx_len_reg;
  logic [DramAddrWidth-1:0] trx_addr_reg;

  logic wr_elig, rd_elig, pick_write;
  logic cmd_valid, cmd_fire;
  logic unused_addr_bits;

  // Queue entries carry the already-converted word address
  assign cmd_in[RdIdx] = {bus.ar_addr[S+DramAddrWidth-1:S], bus.ar_len};
  assign cmd_in[WrIdx] = {bus.aw_addr[S+DramAddrWidth-1:S], bus.aw_len};
  assign cmd_push[RdIdx] = bus.ar_valid && !cmd_full[RdIdx];
  assign cmd_push[WrIdx] = bus.aw_valid && !cmd_full[WrIdx];
  assign cmd_pop[RdIdx]  = cmd_fire && !trx_is_write_reg;
  assign cmd_pop[WrIdx]  = cmd_fire && trx_is_write_reg;

  assign unused_addr_bits = ^{bus.ar_addr[S-1:0], bus.ar_addr[AXI_ADDR_WIDTH-1:S+DramAddrWidth],
                              bus.aw_addr[S-1:0], bus.aw_addr[AXI_ADDR_WIDTH-1:S+DramAddrWidth]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmd_fifo
      buffer_req_fifo #(.Width(CmdWidth), .Depth(BufferDepth)) u_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (cmd_push[gi]),
        .push_data (cmd_in[gi]),
        .pop       (cmd_pop[gi]),
        .head      (cmd_head[gi]),
        .empty     (cmd_empty[gi]),
        .full      (cmd_full[gi])
      );
    end
  endgenerate

  assign w_push = bus.w_valid && !w_full;
  assign w_pop  = !w_empty && bus.w_phy_ready;

  buffer_req_fifo #(.Width(WWidth), .Depth(WBufDepth)) u_w_fifo (
    .clk       (clk_i),
    .srst      (rst_i),
    .push      (w_push),
    .push_data ({bus.w_data, bus.w_strb}),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign aw_need  = CreditWidth'(cmd_head[WrIdx][DramLenWidth-1:0]) + CreditWidth'(1);
  assign sel_need = CreditWidth'(trx_len_reg) + CreditWidth'(1);
  assign wr_elig  = !cmd_empty[WrIdx] && (w_credit_reg >= aw_need);
  assign rd_elig  = !cmd_empty[RdIdx];
  // On a tie the type that did not win last time goes next
  assign pick_write = (wr_elig && rd_elig) ? !last_was_write_reg : wr_elig;
  assign cmd_fire   = cmd_valid && bus.cmd_ready;

  always_comb begin
    w_credit_next = w_credit_reg;
    if (w_push) w_credit_next = w_credit_next + CreditWidth'(1);
    if (cmd_fire && trx_is_write_reg) w_credit_next = w_credit_next - sel_need;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg          <= SELECT;
      w_credit_reg       <= '0;
      last_was_write_reg <= 1'b1;
      trx_is_write_reg   <= 1'b0;
      trx_len_reg        <= '0;
      trx_addr_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      w_credit_reg <= w_credit_next;
      if (state_reg == SELECT && (wr_elig || rd_elig)) begin
        trx_is_write_reg <= pick_write;
        trx_len_reg  <= pick_write ? cmd_head[WrIdx][DramLenWidth-1:0]
                                   : cmd_head[RdIdx][DramLenWidth-1:0];
        trx_addr_reg <= pick_write ? cmd_head[WrIdx][CmdWidth-1:DramLenWidth]
                                   : cmd_head[RdIdx][CmdWidth-1:DramLenWidth];
      end
      if (cmd_fire) last_was_write_reg <= trx_is_write_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SELECT:  if (wr_elig || rd_elig) state_next = ISSUE;
      ISSUE:   if (cmd_fire) state_next = SELECT;
      default: state_next = SELECT;
    endcase
  end

  always_comb begin
    cmd_valid = (state_reg == ISSUE) && bus.buf_resp_ready;
  end

  assign bus.cmd_valid    = cmd_valid;
  assign bus.trx_is_write = trx_is_write_reg;
  assign bus.trx_len      = trx_len_reg;
  assign bus.trx_addr     = trx_addr_reg;
  assign bus.aw_ready     = !cmd_full[WrIdx];
  assign bus.ar_ready     = !cmd_full[RdIdx];
  assign bus.w_ready      = !w_full;
  assign bus.w_phy_valid  = !w_empty;
  // Stale RAM contents are masked so an empty buffer shows zeros
  assign bus.w_phy_data   = w_empty ? '0 : w_head[WWidth-1:DramStrbWidth];
  assign bus.w_phy_strb   = w_empty ? '0 : w_head[DramStrbWidth-1:0];
endmodule

// File: tb/tb_buffer_req.sv
// Bench for buffer_req: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the request buffer.
module tb_buffer_req;
  localparam int DW = 256, SW = 32, LW = 6, AW = 24, XW = 48;
  localparam int CDEPTH = 4, WDEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_req_if bus ();
  buffer_req dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; } cmd_t;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; } word_t;

  cmd_t  aw_q[$];
  cmd_t  ar_q[$];
  word_t w_q[$];
  int    credit = 0;
  bit    lww = 1'b1;
  bit    have_sel = 1'b0;
  bit    sel_write = 1'b0;
  logic [LW-1:0] sel_len = '0;
  logic [AW-1:0] sel_addr = '0;
  bit    issued[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare outputs for the current cycle, then advance the model over the edge
  task automatic cycle();
    bit fire, wr_elig, rd_elig, pick, aw_ok, ar_ok, w_ok;
    word_t wd;
    cmd_t  c;
    #1;
    aw_ok = aw_q.size() < CDEPTH;
    ar_ok = ar_q.size() < CDEPTH;
    w_ok  = w_q.size() < WDEPTH;
    chk("aw_ready", bus.aw_ready, aw_ok);
    chk("ar_ready", bus.ar_ready, ar_ok);
    chk("w_ready", bus.w_ready, w_ok);
    chk("cmd_valid", bus.cmd_valid, have_sel && bus.buf_resp_ready);
    chk("trx_is_write", bus.trx_is_write, sel_write);
    chk("trx_len", bus.trx_len, sel_len);
    chk("trx_addr", bus.trx_addr, sel_addr);
    chk("w_phy_valid", bus.w_phy_valid, w_q.size() > 0);
    if (w_q.size() > 0) begin
      chk("w_phy_data", bus.w_phy_data, w_q[0].data);
      chk("w_phy_strb", bus.w_phy_strb, w_q[0].strb);
    end
    if (bus.cmd_valid && bus.cmd_ready && !rst) issued.push_back(bus.trx_is_write);

    if (rst) begin
      aw_q.delete(); ar_q.delete(); w_q.delete();
      credit = 0; lww = 1'b1; have_sel = 1'b0;
      sel_write = 1'b0; sel_len = '0; sel_addr = '0;
    end else begin
      fire    = have_sel && bus.buf_resp_ready && bus.cmd_ready;
      wr_elig = aw_q.size() > 0 && credit >= int'(aw_q[0].len) + 1;
      rd_elig = ar_q.size() > 0;
      if (w_q.size() > 0 && bus.w_phy_ready) void'(w_q.pop_front());
      if (fire) begin
        if (sel_write) begin
          credit -= int'(sel_len) + 1;
          void'(aw_q.pop_front());
        end else begin
          void'(ar_q.pop_front());
        end
        lww = sel_write;
        have_sel = 1'b0;
      end else if (!have_sel && (wr_elig || rd_elig)) begin
        pick = (wr_elig && rd_elig) ? !lww : wr_elig;
        c = pick ? aw_q[0] : ar_q[0];
        sel_write = pick; sel_len = c.len; sel_addr = c.addr;
        have_sel = 1'b1;
      end
      if (w_ok && bus.w_valid) begin
        wd.data = bus.w_data; wd.strb = bus.w_strb;
        w_q.push_back(wd);
        credit++;
      end
      if (aw_ok && bus.aw_valid) begin
        c.addr = AW'(bus.aw_addr / 32); c.len = bus.aw_len;
        aw_q.push_back(c);
      end
      if (ar_ok && bus.ar_valid) begin
        c.addr = AW'(bus.ar_addr / 32); c.len = bus.ar_len;
        ar_q.push_back(c);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_len = '0;
    bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_len = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0;
    bus.buf_resp_ready = 1; bus.cmd_ready = 1; bus.w_phy_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; set_idle();
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic rand_word();
    for (int i = 0; i < DW / 32; i++) bus.w_data[i*32 +: 32] = $urandom();
    bus.w_strb = $urandom();
  endtask

  task automatic rand_inputs();
    bus.aw_valid = ($urandom_range(0, 99) < 35);
    bus.aw_addr  = XW'({$urandom(), $urandom()});
    bus.aw_len   = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
    bus.ar_valid = ($urandom_range(0, 99) < 35);
    bus.ar_addr  = XW'({$urandom(), $urandom()});
    bus.ar_len   = 6'($urandom_range(0, 63));
    bus.w_valid  = ($urandom_range(0, 99) < 60);
    rand_word();
    bus.buf_resp_ready = ($urandom_range(0, 99) < 80);
    bus.cmd_ready      = ($urandom_range(0, 99) < 70);
    bus.w_phy_ready    = ($urandom_range(0, 99) < 50);
    rst = ($urandom_range(0, 599) == 0);
  endtask

  initial begin
    rst = 1; set_idle();
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_aw_ready", bus.aw_ready, 1);
    chk("rst_w_phy_valid", bus.w_phy_valid, 0);
    chk("rst_trx_addr", bus.trx_addr, 0);

    // Single write 0x1000 len 3, then four data beats
    bus.aw_valid = 1; bus.aw_addr = 48'h1000; bus.aw_len = 6'd3;
    cycle();
    bus.aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      bus.w_valid = 1; rand_word();
      #1; chk("wr_no_early_cmd", bus.cmd_valid, 0);
      cycle();
    end
    bus.w_valid = 0;
    #1; chk("wr_select_cycle", bus.cmd_valid, 0);
    cycle();
    #1;
    chk("wr_cmd_valid", bus.cmd_valid, 1);
    chk("wr_is_write", bus.trx_is_write, 1);
    chk("wr_addr", bus.trx_addr, 24'h80);
    chk("wr_len", bus.trx_len, 3);
    cycle();
    // Credit must be exhausted: a len-0 write waits for its word
    bus.w_phy_ready = 1;
    bus.aw_valid = 1; bus.aw_addr = 48'h0; bus.aw_len = 6'd0;
    cycle();
    bus.aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("no_credit_no_cmd", bus.cmd_valid, 0);
      cycle();
    end
    bus.w_valid = 1; rand_word(); cycle();
    bus.w_valid = 0;
    repeat (4) cycle();
    bus.w_phy_ready = 0;

    // Read only
    bus.ar_valid = 1; bus.ar_addr = 48'h2040; bus.ar_len = 6'd0;
    cycle();
    bus.ar_valid = 0;
    #1; chk("rd_select_cycle", bus.cmd_valid, 0);
    cycle();
    #1;
    chk("rd_cmd_valid", bus.cmd_valid, 1);
    chk("rd_is_write", bus.trx_is_write, 0);
    chk("rd_addr", bus.trx_addr, 24'h102);
    cycle();
    for (int i = 0; i < 2; i++) begin
      #1; chk("rd_queue_empty", bus.cmd_valid, 0);
      cycle();
    end

    // Backpressure: five AR attempts with the controller stalled
    bus.cmd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.ar_valid = 1; bus.ar_addr = 48'h4000 + 48'(i * 32); bus.ar_len = 6'(i);
      #1; chk("bp_ar_ready", bus.ar_ready, i < 4);
      cycle();
    end
    bus.ar_valid = 0; bus.buf_resp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_cmd_valid", bus.cmd_valid, 0);
      chk("bp_trx_addr", bus.trx_addr, 24'h200);
      chk("bp_trx_len", bus.trx_len, 0);
      cycle();
    end
    bus.buf_resp_ready = 1; bus.cmd_ready = 1;
    repeat (12) cycle();

    // Fair arbitration from reset: R, W, R, W
    do_reset();
    issued.delete();
    bus.w_phy_ready = 1;
    for (int i = 0; i < 2; i++) begin
      bus.aw_valid = 1; bus.aw_addr = 48'h100 + 48'(i * 32); bus.aw_len = 6'd0;
      bus.ar_valid = 1; bus.ar_addr = 48'h800 + 48'(i * 32); bus.ar_len = 6'd0;
      bus.w_valid = 1; rand_word();
      cycle();
    end
    set_idle(); bus.w_phy_ready = 1;
    repeat (12) cycle();
    chk("arb_count", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("arb_order", issued[i], (i % 2) == 1);

    // Credit race: the handshake-cycle W push survives as one credit
    do_reset();
    bus.aw_valid = 1; bus.aw_addr = 48'h300; bus.aw_len = 6'd3;
    cycle();
    bus.aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      bus.w_valid = 1; rand_word(); cycle();
    end
    bus.w_valid = 0;
    #1; chk("race_select", bus.cmd_valid, 0);
    cycle();
    bus.w_valid = 1; rand_word();
    #1; chk("race_cmd_valid", bus.cmd_valid, 1);
    chk("race_is_write", bus.trx_is_write, 1);
    cycle();
    bus.w_valid = 0;
    bus.aw_valid = 1; bus.aw_addr = 48'h400; bus.aw_len = 6'd0;
    cycle();
    bus.aw_valid = 0;
    cycle();
    #1;
    chk("race_leftover_cmd", bus.cmd_valid, 1);
    chk("race_leftover_addr", bus.trx_addr, 24'h20);
    cycle();
    bus.aw_valid = 1; bus.aw_addr = 48'h500; bus.aw_len = 6'd0;
    cycle();
    bus.aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("race_credit_zero", bus.cmd_valid, 0);
      cycle();
    end

    // Reset mid-ISSUE with ten buffered words
    do_reset();
    bus.buf_resp_ready = 0;
    for (int i = 0; i < 10; i++) begin
      bus.aw_valid = (i == 0); bus.aw_addr = 48'h600; bus.aw_len = 6'd3;
      bus.w_valid = 1; rand_word();
      cycle();
    end
    set_idle();
    rst = 1;
    cycle();
    rst = 0;
    #1;
    chk("mid_rst_cmd_valid", bus.cmd_valid, 0);
    chk("mid_rst_w_phy_valid", bus.w_phy_valid, 0);
    chk("mid_rst_aw_ready", bus.aw_ready, 1);
    chk("mid_rst_ar_ready", bus.ar_ready, 1);
    chk("mid_rst_w_ready", bus.w_ready, 1);
    cycle();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      cycle();
    end
    rst = 0; set_idle(); bus.w_phy_ready = 1;
    repeat (300) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
